// File: rtl/basic_sysid_checker_if.sv
// Avalon-MM read-only bus between the system-ID checker (master) and the
// system-ID slave. Clock and reset are carried as plain ports by the users.
interface basic_sysid_checker_if;
    logic [1:0]  avm_SysID_address;
    logic        avm_SysID_read;
    logic [31:0] avm_SysID_readdata;
    logic        avm_SysID_waitrequest;

    modport master (
        output avm_SysID_address,
        output avm_SysID_read,
        input  avm_SysID_readdata,
        input  avm_SysID_waitrequest
    );

    modport slave (
        input  avm_SysID_address,
        input  avm_SysID_read,
        output avm_SysID_readdata,
        output avm_SysID_waitrequest
    );
endinterface

// File: rtl/basic_sysid_checker.sv
// Reads the four system-ID words at boot or on request, validates vendor,
// version and both test patterns, and reports the verdict on status outputs.
module basic_sysid_checker #(
    parameter logic [15:0] EXPECT_VENDOR = 16'hEA68,
    parameter logic [15:0] MIN_VERSION   = 16'h0001,
    parameter logic [31:0] PATTERN_A     = 32'hA5A5A5A5,
    parameter logic [31:0] PATTERN_B     = 32'h5A5A5A5A,
    parameter logic [7:0]  TIMEOUT       = 8'd255,
    parameter bit          AUTO_START    = 1'b1
) (
    input  logic                         csi_MCLK_clk,
    input  logic                         rsi_MRST_reset,
    basic_sysid_checker_if.master        avm,
    input  logic                         coe_check_start,
    output logic                         coe_check_busy,
    output logic                         coe_check_done,
    output logic                         coe_check_pass,
    output logic [2:0]                   coe_fail_code,
    output logic [15:0]                  coe_vendor_id,
    output logic [15:0]                  coe_version,
    output logic [31:0]                  coe_ext_id
);

    typedef enum logic [1:0] {IDLE, RD, CHK, DONE} state_t;

    localparam logic [2:0] FAIL_NONE    = 3'd0;
    localparam logic [2:0] FAIL_VENDOR  = 3'd1;
    localparam logic [2:0] FAIL_VERSION = 3'd2;
    localparam logic [2:0] FAIL_PAT_A   = 3'd3;
    localparam logic [2:0] FAIL_PAT_B   = 3'd4;
    localparam logic [2:0] FAIL_TIMEOUT = 3'd5;

    state_t      state;
    logic [1:0]  n;
    logic [7:0]  wait_cnt;
    logic [2:0]  fail;
    logic        auto_pend;
    logic [31:0] word_p0;
    logic [2:0]  chk_fail;

    function automatic logic [2:0] word_check(input logic [1:0] idx, input logic [31:0] w);
        logic [2:0] f;
        f = FAIL_NONE;
        case (idx)
            2'd0: begin
                if (w[31:16] != EXPECT_VENDOR)
                    f = FAIL_VENDOR;
                else if (w[15:0] < MIN_VERSION)
                    f = FAIL_VERSION;
            end
            2'd1: f = FAIL_NONE;
            2'd2: if (w != PATTERN_A) f = FAIL_PAT_A;
            2'd3: if (w != PATTERN_B) f = FAIL_PAT_B;
            default: f = FAIL_NONE;
        endcase
        return f;
    endfunction

    assign chk_fail = word_check(n, word_p0);

    // RD -> CHK boundary: the accepted word is held for evaluation
    always_ff @(posedge csi_MCLK_clk) begin
        if (state == RD && !avm.avm_SysID_waitrequest)
            word_p0 <= avm.avm_SysID_readdata;
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset) begin
        if (!rsi_MRST_reset) begin
            state                 <= IDLE;
            n                     <= 2'd0;
            wait_cnt              <= 8'd0;
            fail                  <= FAIL_NONE;
            auto_pend             <= AUTO_START;
            avm.avm_SysID_address <= 2'd0;
            avm.avm_SysID_read    <= 1'b0;
            coe_check_busy        <= 1'b0;
            coe_check_done        <= 1'b0;
            coe_check_pass        <= 1'b0;
            coe_fail_code         <= FAIL_NONE;
            coe_vendor_id         <= 16'd0;
            coe_version           <= 16'd0;
            coe_ext_id            <= 32'd0;
        end else begin
            auto_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (coe_check_start || auto_pend) begin
                        n                     <= 2'd0;
                        wait_cnt              <= 8'd0;
                        fail                  <= FAIL_NONE;
                        avm.avm_SysID_address <= 2'd0;
                        avm.avm_SysID_read    <= 1'b1;
                        coe_check_busy        <= 1'b1;
                        state                 <= RD;
                    end
                end

                RD: begin
                    if (avm.avm_SysID_waitrequest) begin
                        // The cycle that would bring the count to TIMEOUT ends the read
                        if (wait_cnt == TIMEOUT - 8'd1) begin
                            wait_cnt           <= 8'd0;
                            fail               <= FAIL_TIMEOUT;
                            avm.avm_SysID_read <= 1'b0;
                            state              <= DONE;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else begin
                        wait_cnt           <= 8'd0;
                        avm.avm_SysID_read <= 1'b0;
                        state              <= CHK;
                    end
                end

                CHK: begin
                    if (n == 2'd0) begin
                        coe_vendor_id <= word_p0[31:16];
                        coe_version   <= word_p0[15:0];
                    end
                    if (n == 2'd1)
                        coe_ext_id <= word_p0;
                    if (chk_fail != FAIL_NONE) begin
                        fail  <= chk_fail;
                        state <= DONE;
                    end else if (n == 2'd3) begin
                        state <= DONE;
                    end else begin
                        n                     <= n + 2'd1;
                        avm.avm_SysID_address <= n + 2'd1;
                        avm.avm_SysID_read    <= 1'b1;
                        state                 <= RD;
                    end
                end

                DONE: begin
                    // First DONE cycle publishes the verdict; busy masks start until then
                    if (coe_check_busy) begin
                        coe_check_busy <= 1'b0;
                        coe_check_done <= 1'b1;
                        coe_check_pass <= (fail == FAIL_NONE);
                        coe_fail_code  <= fail;
                    end else if (coe_check_start) begin
                        n                     <= 2'd0;
                        wait_cnt              <= 8'd0;
                        fail                  <= FAIL_NONE;
                        avm.avm_SysID_address <= 2'd0;
                        avm.avm_SysID_read    <= 1'b1;
                        coe_check_busy        <= 1'b1;
                        coe_check_done        <= 1'b0;
                        coe_check_pass        <= 1'b0;
                        coe_fail_code         <= FAIL_NONE;
                        coe_vendor_id         <= 16'd0;
                        coe_version           <= 16'd0;
                        coe_ext_id            <= 32'd0;
                        state                 <= RD;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
